// File: rtl/av_write_arbiter_if.sv
// Write-only Avalon-MM link: one requester (master) driving one responder (slave).
interface av_write_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  write;
    logic                  waitrequest;

    modport master (
        output address,
        output writedata,
        output write,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  writedata,
        input  write,
        output waitrequest
    );
endinterface

// File: rtl/av_write_arbiter.sv
// Two-port Avalon-MM write arbiter: visor (m0) and target MCU (m1) share one
// downstream master port. Round-robin on ties, bounded back-to-back hold, and
// a watchdog that drops writes the downstream slave stalls indefinitely.
module av_write_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int HOLD_MAX   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                     sysclk,
    input  logic                     sysreset_n,
    av_write_arbiter_if.slave        m0,
    av_write_arbiter_if.slave        m1,
    av_write_arbiter_if.master       av,
    output logic [1:0]               grant,
    output logic [1:0]               timeout_flag,
    input  logic                     timeout_clear
);
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam int WAIT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t              state, state_n;
    logic                gnt, gnt_n;
    logic                last_gnt, last_gnt_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic [WAIT_W-1:0]   wait_cnt, wait_n;
    logic [1:0]          flag_n;

    logic                  sel_write;
    logic                  other_write;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_writedata;

    assign sel_write     = gnt ? m1.write     : m0.write;
    assign other_write   = gnt ? m0.write     : m1.write;
    assign sel_address   = gnt ? m1.address   : m0.address;
    assign sel_writedata = gnt ? m1.writedata : m0.writedata;

    // Arbitration state and counters; reset drops any in-flight write silently.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state        <= IDLE;
            gnt          <= 1'b0;
            last_gnt     <= 1'b1;
            hold_cnt     <= '0;
            wait_cnt     <= '0;
            timeout_flag <= '0;
        end else begin
            state        <= state_n;
            gnt          <= gnt_n;
            last_gnt     <= last_gnt_n;
            hold_cnt     <= hold_n;
            wait_cnt     <= wait_n;
            timeout_flag <= flag_n;
        end
    end

    // Next-state, downstream mux, requester stalls and watchdog abort.
    always_comb begin
        state_n        = state;
        gnt_n          = gnt;
        last_gnt_n     = last_gnt;
        hold_n         = hold_cnt;
        wait_n         = wait_cnt;
        flag_n         = timeout_clear ? 2'b00 : timeout_flag;
        av.address     = '0;
        av.writedata   = '0;
        av.write       = 1'b0;
        m0.waitrequest = 1'b1;
        m1.waitrequest = 1'b1;
        grant          = 2'b00;

        case (state)
            IDLE: begin
                if (m0.write || m1.write) begin
                    state_n = BUSY;
                    gnt_n   = (m0.write && m1.write) ? ~last_gnt : m1.write;
                    hold_n  = '0;
                    wait_n  = '0;
                end
            end
            BUSY: begin
                grant        = gnt ? 2'b10 : 2'b01;
                av.address   = sel_address;
                av.writedata = sel_writedata;
                av.write     = sel_write;
                if (gnt) m1.waitrequest = av.waitrequest;
                else     m0.waitrequest = av.waitrequest;

                if (!sel_write) begin
                    state_n    = IDLE;
                    last_gnt_n = gnt;
                    wait_n     = '0;
                end else if (!av.waitrequest) begin
                    wait_n = '0;
                    if (hold_cnt != HOLD_SAT) hold_n = hold_cnt + 1'b1;
                    // hold_cnt+1 >= HOLD_MAX rewritten as hold_cnt >= HOLD_MAX-1
                    if (other_write && (hold_cnt >= HOLD_LAST)) begin
                        state_n    = IDLE;
                        last_gnt_n = gnt;
                    end
                end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
                    // Abort: drop the write downstream but release the requester.
                    av.write = 1'b0;
                    if (gnt) m1.waitrequest = 1'b0;
                    else     m0.waitrequest = 1'b0;
                    flag_n[gnt] = 1'b1;
                    state_n     = IDLE;
                    last_gnt_n  = gnt;
                    wait_n      = '0;
                end else if (TIMEOUT != 0) begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_av_write_arbiter.sv
// Bench for av_write_arbiter: directed timing/abort/reset scenarios plus a
// randomized phase, with a scoreboard monitor on the downstream port.
module tb_av_write_arbiter;
    localparam int HOLD_MAX = 4;
    localparam int TIMEOUT  = 8;

    logic       sysclk = 1'b0;
    logic       sysreset_n;
    logic [1:0] grant;
    logic [1:0] timeout_flag;
    logic       timeout_clear;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    av_write_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) m0_if ();
    av_write_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) m1_if ();
    av_write_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) av_if ();

    av_write_arbiter #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16),
        .HOLD_MAX  (HOLD_MAX),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .sysclk       (sysclk),
        .sysreset_n   (sysreset_n),
        .m0           (m0_if),
        .m1           (m1_if),
        .av           (av_if),
        .grant        (grant),
        .timeout_flag (timeout_flag),
        .timeout_clear(timeout_clear)
    );

    // 100 MHz clock.
    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic req(input int r, input logic [15:0] a, input logic [15:0] d, input bit push);
        if (r == 0) begin
            m0_if.address = a; m0_if.writedata = d; m0_if.write = 1'b1;
            if (push) exp_q0.push_back({a, d});
        end else begin
            m1_if.address = a; m1_if.writedata = d; m1_if.write = 1'b1;
            if (push) exp_q1.push_back({a, d});
        end
    endtask

    task automatic drop(input int r);
        if (r == 0) m0_if.write = 1'b0;
        else        m1_if.write = 1'b0;
    endtask

    task automatic do_reset();
        sysreset_n = 1'b0;
        repeat (2) tick();
        sysreset_n = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: every accepted downstream write must be the oldest
    // outstanding write of the granted requester; also checks grant gaps and hold bound.
    logic [1:0] prev_grant = 2'b00;
    int         streak     = 0;
    always @(negedge sysclk) begin
        bit          r;
        bit          other;
        logic [31:0] act;
        if (!sysreset_n) begin
            prev_grant = 2'b00;
            streak     = 0;
        end else begin
            if (grant != 2'b00 && prev_grant != 2'b00) chk("switch_gap", grant, prev_grant);
            if (grant != prev_grant) streak = 0;
            if (av_if.write && !av_if.waitrequest) begin
                chk("grant_onehot", (grant == 2'b01 || grant == 2'b10), 1);
                r     = grant[1];
                act   = {av_if.address, av_if.writedata};
                other = r ? m0_if.write : m1_if.write;
                if (r == 1'b0) begin
                    chk("m0_queue_nonempty", exp_q0.size() != 0, 1);
                    if (exp_q0.size() != 0) chk("m0_write", act, exp_q0.pop_front());
                    chk("m0_sees_accept", m0_if.waitrequest, 0);
                end else begin
                    chk("m1_queue_nonempty", exp_q1.size() != 0, 1);
                    if (exp_q1.size() != 0) chk("m1_write", act, exp_q1.pop_front());
                    chk("m1_sees_accept", m1_if.waitrequest, 0);
                end
                if (other) begin
                    streak++;
                    chk("hold_bound", streak <= HOLD_MAX, 1);
                end
            end
            prev_grant = grant;
        end
    end

    // One random cycle: requesters hold until accepted, slave stalls at most 3 cycles in a row.
    int stall_run = 0;
    task automatic step(input bit issuing);
        bit acc0, acc1;
        @(negedge sysclk);
        acc0 = m0_if.write && !m0_if.waitrequest;
        acc1 = m1_if.write && !m1_if.waitrequest;
        @(posedge sysclk);
        #1;
        if (!m0_if.write || acc0) begin
            if (issuing && $urandom_range(0, 99) < 55) req(0, 16'($urandom), 16'($urandom), 1'b1);
            else drop(0);
        end
        if (!m1_if.write || acc1) begin
            if (issuing && $urandom_range(0, 99) < 55) req(1, 16'($urandom), 16'($urandom), 1'b1);
            else drop(1);
        end
        if (stall_run < 3 && $urandom_range(0, 2) == 0) begin
            av_if.waitrequest = 1'b1;
            stall_run++;
        end else begin
            av_if.waitrequest = 1'b0;
            stall_run = 0;
        end
    endtask

    // Directed scenarios, then randomized traffic, then summary.
    initial begin
        int exp_g;
        sysreset_n        = 1'b0;
        timeout_clear     = 1'b0;
        av_if.waitrequest = 1'b0;
        m0_if.write = 1'b0; m0_if.address = '0; m0_if.writedata = '0;
        m1_if.write = 1'b0; m1_if.address = '0; m1_if.writedata = '0;
        repeat (3) tick();

        // Reset values
        chk("rst_av_write", av_if.write, 0);
        chk("rst_av_address", av_if.address, 0);
        chk("rst_av_writedata", av_if.writedata, 0);
        chk("rst_m0_wait", m0_if.waitrequest, 1);
        chk("rst_m1_wait", m1_if.waitrequest, 1);
        chk("rst_grant", grant, 0);
        chk("rst_flag", timeout_flag, 0);
        sysreset_n = 1'b1;
        tick();

        // Single requester
        req(0, 16'h0010, 16'h1234, 1'b1);
        chk("single_grant_N", grant, 2'b00);
        chk("single_wait_N", m0_if.waitrequest, 1);
        tick();
        chk("single_grant", grant, 2'b01);
        chk("single_av_write", av_if.write, 1);
        chk("single_addr", av_if.address, 16'h0010);
        chk("single_data", av_if.writedata, 16'h1234);
        chk("single_m0_wait", m0_if.waitrequest, 0);
        tick();
        drop(0);
        repeat (2) tick();
        chk("single_idle", grant, 2'b00);

        // Tie from reset
        do_reset();
        req(0, 16'hA000, 16'h0001, 1'b1);
        req(1, 16'hB000, 16'h0002, 1'b1);
        tick();
        chk("tie_first", grant, 2'b01);
        chk("tie_m1_wait", m1_if.waitrequest, 1);
        tick();
        drop(0);
        chk("tie_still_m0", grant, 2'b01);
        tick();
        chk("tie_gap", grant, 2'b00);
        chk("tie_gap_write", av_if.write, 0);
        tick();
        chk("tie_second", grant, 2'b10);
        chk("tie_m1_addr", av_if.address, 16'hB000);
        chk("tie_m1_wait_go", m1_if.waitrequest, 0);
        tick();
        drop(1);
        repeat (2) tick();

        // Hold limit: HOLD_MAX accepts per side, one idle cycle between grants
        req(0, 16'($urandom), 16'($urandom), 1'b1);
        req(1, 16'($urandom), 16'($urandom), 1'b1);
        exp_g = 0;
        for (int k = 0; k < 15; k++) begin
            if (exp_g == 1) req(0, 16'($urandom), 16'($urandom), 1'b1);
            if (exp_g == 2) req(1, 16'($urandom), 16'($urandom), 1'b1);
            exp_g = (k % 5 == 0) ? 0 : (((k / 5) % 2 == 0) ? 1 : 2);
            chk("hold_grant", grant, exp_g);
            chk("hold_av_write", av_if.write, (k % 5 != 0));
            tick();
        end
        drop(0);
        chk("hold_tail_gap", grant, 2'b00);
        tick();
        chk("hold_tail_m1", grant, 2'b10);
        tick();
        drop(1);
        repeat (2) tick();

        // Timeout on m1
        av_if.waitrequest = 1'b1;
        req(1, 16'hDEAD, 16'hBEEF, 1'b0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (i < TIMEOUT) begin
                chk("to_stall_write", av_if.write, 1);
                chk("to_stall_wait", m1_if.waitrequest, 1);
            end else begin
                chk("to_abort_write", av_if.write, 0);
                chk("to_abort_wait", m1_if.waitrequest, 0);
                chk("to_abort_grant", grant, 2'b10);
                chk("to_flag_not_yet", timeout_flag, 2'b00);
            end
        end
        tick();
        chk("to_flag_set", timeout_flag, 2'b10);
        chk("to_idle", grant, 2'b00);
        drop(1);
        timeout_clear = 1'b1;
        tick();
        chk("to_flag_clear", timeout_flag, 2'b00);
        timeout_clear = 1'b0;

        // Abort coinciding with timeout_clear on m0
        timeout_clear = 1'b1;
        req(0, 16'h0F0F, 16'h5555, 1'b0);
        repeat (TIMEOUT) tick();
        chk("sc_abort_write", av_if.write, 0);
        chk("sc_flag_before", timeout_flag, 2'b00);
        tick();
        chk("sc_set_wins", timeout_flag, 2'b01);
        timeout_clear = 1'b0;
        drop(0);
        tick();

        // Reset mid-stall
        req(0, 16'h1111, 16'h2222, 1'b0);
        repeat (3) tick();
        chk("rs_stalling", av_if.write, 1);
        #2;
        sysreset_n = 1'b0;
        #1;
        chk("rs_av_write", av_if.write, 0);
        chk("rs_av_address", av_if.address, 0);
        chk("rs_grant", grant, 0);
        chk("rs_m0_wait", m0_if.waitrequest, 1);
        chk("rs_flag", timeout_flag, 0);
        drop(0);
        av_if.waitrequest = 1'b0;
        tick();
        sysreset_n = 1'b1;
        tick();
        req(0, 16'h3000, 16'h0003, 1'b1);
        req(1, 16'h4000, 16'h0004, 1'b1);
        tick();
        chk("rs_tie", grant, 2'b01);
        tick();
        drop(0);
        repeat (2) tick();
        chk("rs_tie_second", grant, 2'b10);
        tick();
        drop(1);
        repeat (2) tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) step(1'b1);
        for (int c = 0; c < 200; c++) begin
            if (!m0_if.write && !m1_if.write) break;
            step(1'b0);
        end
        chk("drain_done", (!m0_if.write && !m1_if.write), 1);
        av_if.waitrequest = 1'b0;
        repeat (3) tick();
        chk("q0_empty", exp_q0.size(), 0);
        chk("q1_empty", exp_q1.size(), 0);
        chk("rand_no_timeout", timeout_flag, 2'b00);
        chk("rand_idle", grant, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
